// File: rtl/counters_pkg.sv
// Shared definitions for the modulo-counter enable path: FSM encoding and
// command decoding used by the prescaler.
package counters_pkg;

    localparam int unsigned DefaultDivWidth = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStep = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CmdNone  = 3'd0,
        CmdClear = 3'd1,
        CmdStop  = 3'd2,
        CmdStart = 3'd3,
        CmdStep  = 3'd4
    } cmd_e;

    // Only the highest-priority command of a cycle takes effect.
    function automatic cmd_e decode_cmd(input logic clear, input logic stop,
                                        input logic start, input logic step);
        if (clear) return CmdClear;
        if (stop)  return CmdStop;
        if (start) return CmdStart;
        if (step)  return CmdStep;
        return CmdNone;
    endfunction

endpackage

// File: rtl/div_shadow_reg.sv
// Pending/active divisor pair; a pending divisor is promoted only when the
// owner opens the apply window (idle, or the edge that ends a tick cycle).
module div_shadow_reg #(
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic                 apply_window,
    output logic [DIV_WIDTH-1:0] div_active,
    output logic                 applying
);

    logic [DIV_WIDTH-1:0] pending_div;
    logic                 pending_valid;
    logic [DIV_WIDTH-1:0] load_value;

    assign load_value = (div_value == '0) ? DIV_WIDTH'(1) : div_value;
    assign applying   = pending_valid && apply_window;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_active    <= DIV_WIDTH'(DEFAULT_DIV);
            pending_div   <= DIV_WIDTH'(DEFAULT_DIV);
            pending_valid <= 1'b0;
        end else begin
            if (applying) begin
                div_active <= pending_div;
            end
            // A load coinciding with an apply becomes the next pending value.
            if (div_load) begin
                pending_div   <= load_value;
                pending_valid <= 1'b1;
            end else if (applying) begin
                pending_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tick_prescaler_ctrl.sv
// Programmable clock prescaler with run/pause/single-step control; emits a
// one-cycle tick used as the enable of a downstream modulo counter.
module tick_prescaler_ctrl
    import counters_pkg::*;
#(
    parameter int unsigned DIV_WIDTH   = DefaultDivWidth,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 step,
    input  logic                 clear,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    output logic                 tick,
    output logic                 running,
    output logic [DIV_WIDTH-1:0] div_active
);

    state_e               state;
    logic [DIV_WIDTH-1:0] cnt;
    cmd_e                 cmd;
    logic                 at_last;
    logic                 wrap;
    logic                 apply_window;
    logic                 applying;

    assign cmd     = decode_cmd(clear, stop, start, step);
    assign at_last = (cnt == div_active - DIV_WIDTH'(1));
    assign tick    = (state != StIdle) && at_last;
    assign running = (state != StIdle);

    // A stop during the tick cycle pauses at the last count, so no wrap occurs.
    assign wrap         = tick && (cmd != CmdStop);
    assign apply_window = (state == StIdle) || wrap;

    div_shadow_reg #(
        .DIV_WIDTH  (DIV_WIDTH),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) u_div_shadow (
        .clk         (clk),
        .reset       (reset),
        .div_load    (div_load),
        .div_value   (div_value),
        .apply_window(apply_window),
        .div_active  (div_active),
        .applying    (applying)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StIdle;
            cnt   <= '0;
        end else begin
            unique case (cmd)
                CmdStop:  state <= StIdle;
                CmdStart: state <= StRun;
                CmdStep: begin
                    if (state == StIdle) begin
                        state <= StStep;
                    end else if (state == StStep && wrap) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    if (state == StStep && wrap) begin
                        state <= StIdle;
                    end
                end
            endcase

            if (cmd == CmdClear || applying) begin
                cnt <= '0;
            end else if (state != StIdle && cmd != CmdStop) begin
                cnt <= at_last ? '0 : cnt + DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_tick_prescaler_ctrl.sv
// Directed bench for tick_prescaler_ctrl with hand-computed tick timing.
module tb_tick_prescaler_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic        step;
    logic        clear;
    logic        div_load;
    logic [15:0] div_value;
    logic        tick;
    logic        running;
    logic [15:0] div_active;

    int checks;
    int errors;
    int nticks;

    tick_prescaler_ctrl #(
        .DIV_WIDTH  (16),
        .DEFAULT_DIV(10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .step      (step),
        .clear     (clear),
        .div_load  (div_load),
        .div_value (div_value),
        .tick      (tick),
        .running   (running),
        .div_active(div_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pause, then load a divisor while idle and let it apply.
    task automatic idle_load(input logic [15:0] val);
        stop = 1'b1;
        cyc();
        stop      = 1'b0;
        div_load  = 1'b1;
        div_value = val;
        cyc();
        div_load = 1'b0;
        cyc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
        clear = 1'b0; div_load = 1'b0; div_value = '0;
        #2;
        cyc();
        reset = 1'b0;
        check("rst_tick", tick, 0);
        check("rst_running", running, 0);
        check("rst_div", div_active, 10);

        // Default divisor 10: ticks on cycles 10, 20, 30 after start.
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("run_running", running, 1);
        for (int i = 1; i <= 30; i++) begin
            cyc();
            check("div10_tick", tick, ((i % 10) == 9) ? 1 : 0);
        end
        check("div10_active", div_active, 10);

        // Pause/resume with div 4.
        idle_load(16'd4);
        check("div4_active", div_active, 4);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("pause_running", running, 0);
        nticks = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (tick) nticks++;
        end
        check("pause_noticks", nticks, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("resume_c1", tick, 0);
        cyc();
        check("resume_c2", tick, 1);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            check("div4_tick", tick, ((i % 4) == 0) ? 1 : 0);
        end

        // Single step with div 5.
        idle_load(16'd5);
        check("div5_active", div_active, 5);
        step = 1'b1;
        cyc();
        step = 1'b0;
        check("step_running", running, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("step_tick", tick, (i == 4) ? 1 : 0);
        end
        cyc();
        check("step_done", running, 0);
        nticks = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (tick) nticks++;
        end
        check("step_quiet", nticks, 0);

        // Divisor 8 -> 3 loaded mid-period applies only at the wrap.
        idle_load(16'd8);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        div_load  = 1'b1;
        div_value = 16'd3;
        cyc();
        div_load = 1'b0;
        check("midload_div", div_active, 8);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("div8_tail_tick", tick, (i == 4) ? 1 : 0);
        end
        check("div8_at_tick", div_active, 8);
        cyc();
        check("div3_applied", div_active, 3);
        check("div3_c0", tick, 0);
        for (int i = 1; i <= 9; i++) begin
            cyc();
            check("div3_tick", tick, ((i % 3) == 2) ? 1 : 0);
        end

        // div_value 0 is treated as 1.
        idle_load(16'd0);
        check("div0_active", div_active, 1);
        check("div1_idle_tick", tick, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("div1_tick", tick, 1);
            cyc();
        end

        // Reset mid-run with div 6 at cnt 4.
        idle_load(16'd6);
        check("div6_active", div_active, 6);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("midrst_tick", tick, 0);
        check("midrst_running", running, 0);
        check("midrst_div", div_active, 10);

        // clear wins over stop and start: stays idle, count zeroed.
        clear = 1'b1; stop = 1'b1; start = 1'b1;
        cyc();
        clear = 1'b0; stop = 1'b0; start = 1'b0;
        check("combo_running", running, 0);
        check("combo_tick", tick, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            cyc();
            check("post_clear_tick", tick, (i == 9) ? 1 : 0);
        end

        // Stop in the tick cycle holds at the last count; resume ticks at once.
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("stop_in_tick", tick, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("resume_last_tick", tick, 1);
        cyc();
        check("resume_wrapped", tick, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
